// File: rtl/tank_plant_emulator.sv
// Water-tank plant model driving level-sensor flags back to a pump PLC.
// Level is integrated once per prescaler tick from pump/drain commands.
module tank_plant_emulator #(
  parameter int TICK_DIV    = 1000000,
  parameter int FILL_RATE   = 3,
  parameter int DRAIN_RATE  = 2,
  parameter int LOW_TH      = 40,
  parameter int MID_TH      = 128,
  parameter int HIGH_TH     = 220,
  parameter int THERM_STEP  = 31,
  parameter int SPILL_TICKS = 4
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic       pump1,
  input  logic       pump2,
  input  logic       drain_en,
  input  logic       spill_clr,
  input  logic [7:0] init_level,
  output logic       Low,
  output logic       Mid,
  output logic       High,
  output logic [7:0] water_indication,
  output logic [7:0] level,
  output logic [2:0] plant_state,
  output logic       spill,
  output logic       tick
);
  typedef enum logic [2:0] {
    ST_EMPTY    = 3'd0,
    ST_STEADY   = 3'd1,
    ST_FILLING  = 3'd2,
    ST_DRAINING = 3'd3,
    ST_FULL     = 3'd4
  } state_t;

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(SPILL_TICKS + 1);
  localparam logic [PW-1:0] PS_PRE  = PW'(TICK_DIV - 2);
  localparam logic [SW-1:0] SP_MAX  = SW'(SPILL_TICKS);

  logic [PW-1:0]     ps_cnt;
  logic [SW-1:0]     sp_cnt, sp_cnt_nxt;
  logic signed [9:0] net;
  int                sum;
  logic [7:0]        level_nxt, sense_src, bar_nxt;
  logic              full_in;
  state_t            st_q, st_nxt, st_init;

  assign plant_state = st_q;

  always_comb begin
    net = 10'(FILL_RATE * (int'(pump1) + int'(pump2)) - DRAIN_RATE * int'(drain_en));
    sum = int'(level) + int'(net);
    // Saturate at both rails; the tank never wraps.
    if (sum > 255)    level_nxt = 8'hFF;
    else if (sum < 0) level_nxt = 8'h00;
    else              level_nxt = 8'(sum);

    if (level_nxt == 8'hFF)      st_nxt = ST_FULL;
    else if (level_nxt == 8'h00) st_nxt = ST_EMPTY;
    else if (net > 0)            st_nxt = ST_FILLING;
    else if (net < 0)            st_nxt = ST_DRAINING;
    else                         st_nxt = ST_STEADY;

    if (init_level == 8'h00)      st_init = ST_EMPTY;
    else if (init_level == 8'hFF) st_init = ST_FULL;
    else                          st_init = ST_STEADY;

    // Holding the counter between ticks keeps spill re-asserting while saturated.
    full_in    = (level == 8'hFF) && (net > 0);
    sp_cnt_nxt = sp_cnt;
    if (tick) begin
      if (!full_in)              sp_cnt_nxt = '0;
      else if (sp_cnt != SP_MAX) sp_cnt_nxt = sp_cnt + 1'b1;
    end

    sense_src = reset ? init_level : level;
    bar_nxt   = '0;
    for (int i = 0; i < 8; i++)
      bar_nxt[i] = int'(sense_src) >= THERM_STEP * (i + 1);
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      ps_cnt <= '0;
      tick   <= 1'b0;
      level  <= init_level;
      st_q   <= st_init;
      sp_cnt <= '0;
      spill  <= 1'b0;
    end else begin
      // tick is registered one count early so it coincides with count TICK_DIV-1.
      ps_cnt <= tick ? '0 : ps_cnt + 1'b1;
      tick   <= (ps_cnt == PS_PRE) && !tick;
      if (tick) begin
        level <= level_nxt;
        st_q  <= st_nxt;
      end
      sp_cnt <= sp_cnt_nxt;
      if (sp_cnt_nxt == SP_MAX) spill <= 1'b1;
      else if (spill_clr)       spill <= 1'b0;
    end
  end

  // Sensors follow level with one cycle of latency, and init_level during reset.
  always_ff @(posedge CLK100MHZ) begin
    Low              <= int'(sense_src) >= LOW_TH;
    Mid              <= int'(sense_src) >= MID_TH;
    High             <= int'(sense_src) >= HIGH_TH;
    water_indication <= bar_nxt;
  end
endmodule

// File: tb/tb_tank_plant_emulator.sv
// Scoreboard bench for tank_plant_emulator: stimulus queues per-tick expectations,
// a monitor pops one per tick strobe and compares level/state/spill/sensors.
module tb_tank_plant_emulator;
  localparam logic [2:0] S_EMPTY = 3'd0, S_STEADY = 3'd1, S_FILL = 3'd2,
                         S_DRAIN = 3'd3, S_FULL = 3'd4;

  logic       CLK100MHZ = 1'b0;
  logic       reset = 1'b1, pump1 = 1'b0, pump2 = 1'b0, drain_en = 1'b0, spill_clr = 1'b0;
  logic [7:0] init_level = 8'd0;
  logic       Low, Mid, High, spill, tick;
  logic [7:0] water_indication, level;
  logic [2:0] plant_state;

  int checks = 0;
  int failures = 0;

  typedef struct { logic [7:0] lvl; logic [2:0] st; logic sp; } exp_t;
  exp_t q[$];

  tank_plant_emulator #(.TICK_DIV(4)) dut (
    .CLK100MHZ(CLK100MHZ), .reset(reset), .pump1(pump1), .pump2(pump2),
    .drain_en(drain_en), .spill_clr(spill_clr), .init_level(init_level),
    .Low(Low), .Mid(Mid), .High(High), .water_indication(water_indication),
    .level(level), .plant_state(plant_state), .spill(spill), .tick(tick)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  // {Low, Mid, High, water_indication} expected for a given level.
  function automatic logic [10:0] thr(input logic [7:0] l);
    logic [7:0] w;
    for (int i = 0; i < 8; i++) w[i] = int'(l) >= 31 * (i + 1);
    return {int'(l) >= 40, int'(l) >= 128, int'(l) >= 220, w};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every tick strobe consumes one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK100MHZ);
      if (tick === 1'b1 && !reset) begin
        if (q.size() == 0) begin
          chk("unexpected_tick", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          @(negedge CLK100MHZ);
          chk("level", {24'd0, level}, {24'd0, e.lvl});
          chk("state", {29'd0, plant_state}, {29'd0, e.st});
          chk("spill", {31'd0, spill}, {31'd0, e.sp});
          @(negedge CLK100MHZ);
          chk("sensors", {21'd0, Low, Mid, High, water_indication}, {21'd0, thr(e.lvl)});
        end
      end
    end
  end

  task automatic wait_tick(output int n);
    n = 0;
    while (tick !== 1'b1 && n < 20) begin
      @(negedge CLK100MHZ);
      n++;
    end
  endtask

  task automatic step(input logic [7:0] lvl, input logic [2:0] st, input logic sp);
    int n;
    q.push_back('{lvl: lvl, st: st, sp: sp});
    wait_tick(n);
    chk("tick_seen", {31'd0, tick}, 32'd1);
    @(negedge CLK100MHZ);
    @(negedge CLK100MHZ);
  endtask

  task automatic do_reset(input logic [7:0] init, input int cyc);
    logic [2:0] st;
    reset = 1'b1;
    init_level = init;
    repeat (cyc) @(negedge CLK100MHZ);
    reset = 1'b0;
    st = (init == 8'd0) ? S_EMPTY : (init == 8'hFF) ? S_FULL : S_STEADY;
    chk("rst_level", {24'd0, level}, {24'd0, init});
    chk("rst_state", {29'd0, plant_state}, {29'd0, st});
    chk("rst_spill", {31'd0, spill}, 32'd0);
    chk("rst_tick", {31'd0, tick}, 32'd0);
    chk("rst_sensors", {21'd0, Low, Mid, High, water_indication}, {21'd0, thr(init)});
  endtask

  task automatic latency_step(input logic [7:0] lvl, input logic [2:0] st);
    int n;
    q.push_back('{lvl: lvl, st: st, sp: 1'b0});
    wait_tick(n);
    chk("tick_latency", n, 32'd3);
    @(negedge CLK100MHZ);
    @(negedge CLK100MHZ);
  endtask

  initial begin
    // Reset at empty, first tick on the 4th cycle.
    do_reset(8'd0, 2);
    chk("rst0_bar", {24'd0, water_indication}, 32'h00);
    latency_step(8'd0, S_EMPTY);

    // Single pump fill from empty: +3 per tick, Low rises at 42.
    pump1 = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step(8'(3 * k), S_FILL, 1'b0);
      if (k == 13) chk("low_at_39", {31'd0, Low}, 32'd0);
      if (k == 14) chk("low_at_42", {31'd0, Low}, 32'd1);
    end

    // Both pumps from 250: saturate at 255, spill after 4 more ticks.
    do_reset(8'd250, 2);
    pump1 = 1'b1; pump2 = 1'b1;
    step(8'd255, S_FULL, 1'b0);
    step(8'd255, S_FULL, 1'b0);
    step(8'd255, S_FULL, 1'b0);
    step(8'd255, S_FULL, 1'b0);
    step(8'd255, S_FULL, 1'b1);
    spill_clr = 1'b1;
    @(negedge CLK100MHZ);
    spill_clr = 1'b0;
    chk("spill_clr_while_full", {31'd0, spill}, 32'd1);
    step(8'd255, S_FULL, 1'b1);
    pump1 = 1'b0; pump2 = 1'b0;
    step(8'd255, S_FULL, 1'b1);
    spill_clr = 1'b1;
    @(negedge CLK100MHZ);
    spill_clr = 1'b0;
    chk("spill_clr_after_stop", {31'd0, spill}, 32'd0);
    step(8'd255, S_FULL, 1'b0);

    // Drain from 3: 1, then clamps at 0.
    do_reset(8'd3, 2);
    drain_en = 1'b1;
    step(8'd1, S_DRAIN, 1'b0);
    step(8'd0, S_EMPTY, 1'b0);
    step(8'd0, S_EMPTY, 1'b0);
    spill_clr = 1'b1;
    @(negedge CLK100MHZ);
    spill_clr = 1'b0;
    chk("spill_clr_idle", {31'd0, spill}, 32'd0);

    // Pump plus drain nets +1; mid-tick pump glitches are ignored.
    do_reset(8'd100, 2);
    pump1 = 1'b1; drain_en = 1'b1;
    step(8'd101, S_FILL, 1'b0);
    step(8'd102, S_FILL, 1'b0);
    pump1 = 1'b0;
    @(negedge CLK100MHZ);
    pump1 = 1'b1;
    step(8'd103, S_FILL, 1'b0);
    pump1 = 1'b0;
    step(8'd101, S_DRAIN, 1'b0);
    pump1 = 1'b1;
    @(negedge CLK100MHZ);
    pump1 = 1'b0;
    step(8'd99, S_DRAIN, 1'b0);
    // Reset mid-count restarts the prescaler.
    @(negedge CLK100MHZ);
    do_reset(8'd77, 1);
    latency_step(8'd75, S_DRAIN);

    // Bar-graph at 128 and ramp to 248.
    do_reset(8'd128, 2);
    chk("bar_128", {24'd0, water_indication}, 32'h0F);
    chk("lmh_128", {29'd0, Low, Mid, High}, 32'b110);
    drain_en = 1'b0; pump1 = 1'b1; pump2 = 1'b1;
    for (int k = 1; k <= 20; k++) step(8'(128 + 6 * k), S_FILL, 1'b0);
    chk("bar_248", {24'd0, water_indication}, 32'hFF);
    chk("high_248", {31'd0, High}, 32'd1);

    reset = 1'b1;
    repeat (10) @(negedge CLK100MHZ);
    chk("queue_empty", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
